branch_predictor: RTL and testbench

Fetch-side consumer of branch resolutions produced by the execute-stage branch unit. It holds a direct-mapped BTB with 2-bit saturating counters and answers fetch lookups one cycle after the request. It is trained by resolved branch outcomes. It also compares each resolution against the prediction that travelled with the instruction, and raises a registered redirect (PC plus flush request) on mismatch.

---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor_sat_counter.sv | 26 ++
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared fetch/branch types: program counter, BTB counter and entry layout.
// Counter constants and the fall-through PC helper are common to predictor users.
package branch_predictor_pkg;

  typedef logic [31:0] program_counter_t;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_WEAK_T   = 2'b10;
  localparam bp_ctr_t BP_CTR_STRONG_T = 2'b11;

  // Tag field is sized for the widest legal tag; narrower configs zero-extend.
  localparam int unsigned BP_TAG_MAX_W = 30;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:1]             target;
    bp_ctr_t                 ctr;
  } bp_entry_t;

  function automatic program_counter_t bp_fallthrough(program_counter_t pc, logic compressed);
    return pc + (compressed ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute-stage resolution and redirect signals of the branch predictor.
// master = fetch/execute side, slave = predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic             o_ready;
  logic             i_lookup_valid;
  program_counter_t i_lookup_pc;
  logic             o_pred_valid;
  logic             o_pred_taken;
  program_counter_t o_pred_target;
  logic             i_update_valid;
  program_counter_t i_update_pc;
  logic             i_update_compressed;
  logic             i_update_uncond;
  logic             i_update_taken;
  program_counter_t i_update_target;
  logic             i_update_pred_taken;
  program_counter_t i_update_pred_target;
  logic             o_redirect;
  program_counter_t o_redirect_pc;

  modport master (
    input  o_ready, o_pred_valid, o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
    output i_lookup_valid, i_lookup_pc, i_update_valid, i_update_pc, i_update_compressed,
           i_update_uncond, i_update_taken, i_update_target, i_update_pred_taken,
           i_update_pred_target
  );

  modport slave (
    output o_ready, o_pred_valid, o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
    input  i_lookup_valid, i_lookup_pc, i_update_valid, i_update_pc, i_update_compressed,
           i_update_uncond, i_update_taken, i_update_target, i_update_pred_taken,
           i_update_pred_target
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of a BTB entry's 2-bit saturating counter.
// A miss yields the allocation value; callers only write it back when taken.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  input  logic    uncond,
  input  logic    hit,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (!hit) begin
      if (taken) ctr_next = uncond ? BP_CTR_STRONG_T : BP_CTR_WEAK_T;
    end else if (uncond) begin
      ctr_next = BP_CTR_STRONG_T;
    end else if (taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: registered fetch lookup, training from
// resolved branches, and a registered redirect when a resolution disagrees with its prediction.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 10
) (
  input logic               i_clk,
  input logic               i_rst_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] init_idx;
  bp_entry_t        btb [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  bp_entry_t        lk_entry, up_entry, wr_entry;
  logic             lk_hit, up_hit, up_write, mispredict;
  bp_ctr_t          ctr_next;
  program_counter_t correct_pc;

  assign lk_idx   = bp.i_lookup_pc[IDX_W:1];
  assign lk_tag   = bp.i_lookup_pc[IDX_W+TAG_W:IDX_W+1];
  assign up_idx   = bp.i_update_pc[IDX_W:1];
  assign up_tag   = bp.i_update_pc[IDX_W+TAG_W:IDX_W+1];
  assign lk_entry = btb[lk_idx];
  assign up_entry = btb[up_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == BP_TAG_MAX_W'(lk_tag));
  assign up_hit   = up_entry.valid && (up_entry.tag == BP_TAG_MAX_W'(up_tag));

  assign bp.o_ready = (state == ST_READY);

  bp_sat_counter u_ctr (
    .ctr      (up_entry.ctr),
    .taken    (bp.i_update_taken),
    .uncond   (bp.i_update_uncond),
    .hit      (up_hit),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_idx == IDX_W'(ENTRIES - 1)) state_next = ST_READY;
  end

  always_comb begin
    up_write = (state == ST_READY) && bp.i_update_valid && (up_hit || bp.i_update_taken);
    wr_entry       = up_entry;
    wr_entry.valid = 1'b1;
    wr_entry.tag   = BP_TAG_MAX_W'(up_tag);
    wr_entry.ctr   = ctr_next;
    if (bp.i_update_taken || bp.i_update_uncond) wr_entry.target = bp.i_update_target[31:1];

    mispredict = (bp.i_update_pred_taken != bp.i_update_taken) ||
                 (bp.i_update_taken &&
                  (bp.i_update_pred_target[31:1] != bp.i_update_target[31:1]));
    correct_pc = bp.i_update_taken ? {bp.i_update_target[31:1], 1'b0}
                                   : bp_fallthrough(bp.i_update_pc, bp.i_update_compressed);
  end

  // Array has no reset of its own; the INIT sweep invalidates it after every reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state == ST_INIT) btb[init_idx].valid <= 1'b0;
      else if (up_write)    btb[up_idx]         <= wr_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      init_idx         <= '0;
      bp.o_pred_valid  <= 1'b0;
      bp.o_pred_taken  <= 1'b0;
      bp.o_pred_target <= '0;
      bp.o_redirect    <= 1'b0;
      bp.o_redirect_pc <= '0;
    end else begin
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;

      bp.o_pred_valid  <= bp.i_lookup_valid;
      bp.o_pred_taken  <= 1'b0;
      bp.o_pred_target <= '0;
      if (state == ST_READY && lk_hit && lk_entry.ctr[1]) begin
        bp.o_pred_taken  <= 1'b1;
        bp.o_pred_target <= {lk_entry.target, 1'b0};
      end

      bp.o_redirect <= 1'b0;
      if (state == ST_READY && bp.i_update_valid && mispredict) begin
        bp.o_redirect    <= 1'b1;
        bp.o_redirect_pc <= correct_pc;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level model checked every cycle,
// plus hand-computed expectations at key points of the sequence.
module tb_branch_predictor;

  localparam int unsigned N_ENT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(16), .TAG_W(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bp      (bp_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: BTB as plain arrays, readiness as a cycle count since reset release.
  bit          m_valid [N_ENT];
  int unsigned m_tag   [N_ENT];
  logic [31:0] m_tgt   [N_ENT];
  int          m_ctr   [N_ENT];
  int          rel_cnt = 0;

  bit          exp_rst = 1'b1, exp_ready = 1'b0, exp_pv = 1'b0, exp_pt = 1'b0, exp_rd = 1'b0;
  logic [31:0] exp_ptg = '0, exp_rpc = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rel_cnt = 0;
      for (int i = 0; i < N_ENT; i++) m_valid[i] = 1'b0;
      exp_rst = 1'b1; exp_ready = 1'b0; exp_pv = 1'b0; exp_pt = 1'b0;
      exp_ptg = '0; exp_rd = 1'b0; exp_rpc = '0;
    end else begin
      bit          in_init, mis, hit;
      int unsigned idx, tag;
      logic [31:0] tgt;
      exp_rst = 1'b0;
      in_init = (rel_cnt < N_ENT);

      exp_pv = bp_if.i_lookup_valid; exp_pt = 1'b0; exp_ptg = '0;
      if (!in_init && bp_if.i_lookup_valid) begin
        idx = (bp_if.i_lookup_pc >> 1) % N_ENT;
        tag = (bp_if.i_lookup_pc >> 5) & 32'h3FF;
        if (m_valid[idx] && m_tag[idx] == tag && m_ctr[idx] >= 2) begin
          exp_pt = 1'b1; exp_ptg = m_tgt[idx];
        end
      end

      exp_rd = 1'b0;
      if (!in_init && bp_if.i_update_valid) begin
        tgt = bp_if.i_update_target & ~32'd1;
        mis = (bp_if.i_update_pred_taken != bp_if.i_update_taken) ||
              (bp_if.i_update_taken && ((bp_if.i_update_pred_target & ~32'd1) != tgt));
        if (mis) begin
          exp_rd  = 1'b1;
          exp_rpc = bp_if.i_update_taken ? tgt
                  : bp_if.i_update_pc + (bp_if.i_update_compressed ? 32'd2 : 32'd4);
        end
        idx = (bp_if.i_update_pc >> 1) % N_ENT;
        tag = (bp_if.i_update_pc >> 5) & 32'h3FF;
        hit = m_valid[idx] && m_tag[idx] == tag;
        if (hit) begin
          if (bp_if.i_update_uncond)     m_ctr[idx] = 3;
          else if (bp_if.i_update_taken) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          else                           m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          if (bp_if.i_update_taken || bp_if.i_update_uncond) m_tgt[idx] = tgt;
        end else if (bp_if.i_update_taken) begin
          m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = tgt;
          m_ctr[idx] = bp_if.i_update_uncond ? 3 : 2;
        end
      end

      if (rel_cnt < N_ENT) rel_cnt++;
      exp_ready = (rel_cnt >= N_ENT);
    end
  end

  always @(negedge clk) begin
    check("ready", {31'b0, bp_if.o_ready}, {31'b0, exp_ready});
    check("pred_valid", {31'b0, bp_if.o_pred_valid}, {31'b0, exp_pv});
    check("redirect", {31'b0, bp_if.o_redirect}, {31'b0, exp_rd});
    if (exp_pv || exp_rst) begin
      check("pred_taken", {31'b0, bp_if.o_pred_taken}, {31'b0, exp_pt});
      check("pred_target", bp_if.o_pred_target, exp_ptg);
    end
    if (exp_rd || exp_rst) check("redirect_pc", bp_if.o_redirect_pc, exp_rpc);
  end

  // Drive one cycle of stimulus at posedge+1; on return the outputs for it are visible.
  task automatic op(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                    input bit comp, input bit unc, input bit tk, input logic [31:0] tgt,
                    input bit ptk, input logic [31:0] ptgt);
    bp_if.i_lookup_valid = lv;  bp_if.i_lookup_pc = lpc;
    bp_if.i_update_valid = uv;  bp_if.i_update_pc = upc;
    bp_if.i_update_compressed = comp; bp_if.i_update_uncond = unc;
    bp_if.i_update_taken = tk;  bp_if.i_update_target = tgt;
    bp_if.i_update_pred_taken = ptk; bp_if.i_update_pred_target = ptgt;
    @(posedge clk); #1;
    bp_if.i_lookup_valid = 1'b0; bp_if.i_update_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    op(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic update(input logic [31:0] pc, input bit comp, input bit unc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    op(1'b0, '0, 1'b1, pc, comp, unc, tk, tgt, ptk, ptgt);
  endtask

  task automatic expect_pred(input string name, input bit tk, input logic [31:0] tgt);
    check({name, "_valid"}, {31'b0, bp_if.o_pred_valid}, 32'd1);
    check({name, "_taken"}, {31'b0, bp_if.o_pred_taken}, {31'b0, tk});
    check({name, "_target"}, bp_if.o_pred_target, tgt);
  endtask

  task automatic expect_redir(input string name, input bit rd, input logic [31:0] pc);
    check({name, "_redirect"}, {31'b0, bp_if.o_redirect}, {31'b0, rd});
    if (rd) check({name, "_pc"}, bp_if.o_redirect_pc, pc);
  endtask

  task automatic expect_reset_outputs(input string name);
    check({name, "_ready"}, {31'b0, bp_if.o_ready}, 32'd0);
    check({name, "_pv"}, {31'b0, bp_if.o_pred_valid}, 32'd0);
    check({name, "_pt"}, {31'b0, bp_if.o_pred_taken}, 32'd0);
    check({name, "_ptg"}, bp_if.o_pred_target, 32'd0);
    check({name, "_rd"}, {31'b0, bp_if.o_redirect}, 32'd0);
    check({name, "_rpc"}, bp_if.o_redirect_pc, 32'd0);
  endtask

  task automatic init_sweep(input string name, input bit with_update);
    for (int i = 0; i < N_ENT; i++) begin
      if (with_update && i == 4)
        op(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0);
      else
        lookup(32'h100);
      check({name, "_ready"}, {31'b0, bp_if.o_ready}, (i == N_ENT - 1) ? 32'd1 : 32'd0);
      expect_pred({name, "_lk"}, 1'b0, 32'h0);
      if (with_update && i == 4) expect_redir({name, "_upd"}, 1'b0, '0);
    end
  endtask

  initial begin
    bp_if.i_lookup_valid = 1'b0; bp_if.i_lookup_pc = '0;
    bp_if.i_update_valid = 1'b0; bp_if.i_update_pc = '0;
    bp_if.i_update_compressed = 1'b0; bp_if.i_update_uncond = 1'b0;
    bp_if.i_update_taken = 1'b0; bp_if.i_update_target = '0;
    bp_if.i_update_pred_taken = 1'b0; bp_if.i_update_pred_target = '0;

    repeat (3) begin @(posedge clk); #1; end
    expect_reset_outputs("rst");
    rst_n = 1'b1;
    init_sweep("init", 1'b1);

    lookup(32'h100);                                          expect_pred("post_init", 1'b0, 32'h0);
    update(32'h100, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0);     expect_redir("alloc", 1'b1, 32'h200);
    lookup(32'h100);                                          expect_pred("alloc", 1'b1, 32'h200);
    expect_redir("alloc_after", 1'b0, '0);

    update(32'h100, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h200);     expect_redir("nt1", 1'b1, 32'h104);
    update(32'h100, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h200);     expect_redir("nt2c", 1'b1, 32'h102);
    lookup(32'h100);                                          expect_pred("nt", 1'b0, 32'h0);

    update(32'h100, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0);
    update(32'h100, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0);
    lookup(32'h100);                                          expect_pred("retrain", 1'b1, 32'h200);
    lookup(32'h140);                                          expect_pred("alias_lk", 1'b0, 32'h0);
    update(32'h140, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, '0);      expect_redir("alias_jal", 1'b1, 32'h80);
    lookup(32'h100);                                          expect_pred("alias_evict", 1'b0, 32'h0);
    lookup(32'h140);                                          expect_pred("alias_new", 1'b1, 32'h80);

    update(32'h200, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 32'h300); expect_redir("bad_tgt", 1'b1, 32'h304);
    update(32'h200, 1'b0, 1'b0, 1'b1, 32'h304, 1'b1, 32'h304); expect_redir("good", 1'b0, '0);

    update(32'h400, 1'b0, 1'b0, 1'b1, 32'h500, 1'b0, '0);     expect_redir("b2b_0", 1'b1, 32'h500);
    update(32'h404, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, '0);     expect_redir("b2b_1", 1'b1, 32'h600);
    lookup(32'h0);                                            expect_redir("b2b_end", 1'b0, '0);

    update(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h10); expect_redir("wrap", 1'b1, 32'h0);

    op(1'b1, 32'h106, 1'b1, 32'h106, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0, '0);
    expect_pred("rbw", 1'b0, 32'h0);
    expect_redir("rbw", 1'b1, 32'h2000);
    lookup(32'h106);                                          expect_pred("rbw_next", 1'b1, 32'h2000);

    rst_n = 1'b0;
    lookup(32'h106);
    expect_reset_outputs("midrst");
    lookup(32'h106);
    rst_n = 1'b1;
    init_sweep("reinit", 1'b0);
    lookup(32'h106);                                          expect_pred("cleared", 1'b0, 32'h0);

    repeat (2) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
